// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a word-only Memory: sub-word stores are read-modify-write.
// Optional misaligned-access trapping is enabled with `define MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic         req_write_i,
  input  logic [2:0]   req_funct3_i,
  input  logic [N-1:0] req_addr_i,
  input  logic [N-1:0] req_wdata_i,
  output logic         resp_valid_o,
  output logic [N-1:0] resp_rdata_o,
  output logic         resp_fault_o,
  output logic [N-1:0] mem_address_o,
  output logic [N-1:0] mem_data_write_o,
  output logic         mem_write_enable_o,
  input  logic [N-1:0] mem_data_read_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_e;

  state_e       state_q;
  logic [N-1:0] addr_q, wdata_q, rdata_q, dwrite_q;
  logic [2:0]   funct3_q;
  logic         write_q, mis_q, fault_q, we_q, vld_q, ready_q;

  logic         mis_req;
  logic [N-1:0] shifted, load_val, merged;
  logic [15:0]  half_v;

`ifdef MISALIGN_TRAP_EN
  assign mis_req = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                   (req_funct3_i[1] && req_addr_i[1:0] != 2'b00);
`else
  assign mis_req = 1'b0;
`endif

  // Lane extraction and sign/zero extension of the word returned by Memory.
  assign shifted = mem_data_read_i >> {addr_q[1:0], 3'b000};
  assign half_v  = addr_q[1] ? mem_data_read_i[31:16] : mem_data_read_i[15:0];

  always_comb begin
    load_val = mem_data_read_i;
    if (!funct3_q[1]) begin
      if (funct3_q[0])
        load_val = {{16{half_v[15] & ~funct3_q[2]}}, half_v};
      else
        load_val = {{24{shifted[7] & ~funct3_q[2]}}, shifted[7:0]};
    end
  end

  always_comb begin
    merged = mem_data_read_i;
    if (funct3_q[0])
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      dwrite_q <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
      mis_q    <= 1'b0;
      fault_q  <= 1'b0;
      we_q     <= 1'b0;
      vld_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          addr_q   <= req_addr_i;
          wdata_q  <= req_wdata_i;
          funct3_q <= req_funct3_i;
          write_q  <= req_write_i;
          mis_q    <= mis_req;
          rdata_q  <= '0;
          fault_q  <= 1'b0;
          ready_q  <= 1'b0;
          state_q  <= ACCESS;
          // Word stores need no read, so the write strobe is set up for ACCESS directly.
          if (req_write_i && req_funct3_i[1] && !mis_req) begin
            we_q     <= 1'b1;
            dwrite_q <= req_wdata_i;
          end
        end
        ACCESS: begin
          we_q     <= 1'b0;
          dwrite_q <= '0;
          if (mis_q) begin
            fault_q <= 1'b1;
            vld_q   <= 1'b1;
            state_q <= RESP;
          end else if (!write_q) begin
            rdata_q <= load_val;
            vld_q   <= 1'b1;
            state_q <= RESP;
          end else if (funct3_q[1]) begin
            vld_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            we_q     <= 1'b1;
            dwrite_q <= merged;
            state_q  <= MERGE;
          end
        end
        MERGE: begin
          we_q     <= 1'b0;
          dwrite_q <= '0;
          vld_q    <= 1'b1;
          state_q  <= RESP;
        end
        RESP: begin
          vld_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o        = ready_q;
  assign resp_valid_o       = vld_q;
  assign resp_rdata_o       = rdata_q;
  assign resp_fault_o       = fault_q;
  assign mem_address_o      = {addr_q[N-1:2], 2'b00};
  assign mem_data_write_o   = dwrite_q;
  // Gated by reset so an interrupted read-modify-write never lands.
  assign mem_write_enable_o = we_q & rst_n_i;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-in-MERGE sequence and a
// random phase checked against a byte-level memory reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_fault, mem_we;
  logic [31:0] resp_rdata, mem_address, mem_data_write, mem_data_read;

  load_store_unit #(.N(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_fault_o(resp_fault),
    .mem_address_o(mem_address), .mem_data_write_o(mem_data_write),
    .mem_write_enable_o(mem_we), .mem_data_read_i(mem_data_read)
  );

  always #5 clk = ~clk;

  // Word-wide Memory: combinational read, write on the rising edge.
  logic [31:0] mem [128];
  int wr_cnt = 0;
  assign mem_data_read = mem[mem_address[8:2]];
  always @(posedge clk) if (mem_we) begin
    mem[mem_address[8:2]] <= mem_data_write;
    wr_cnt <= wr_cnt + 1;
  end

  logic [31:0] exp_mem [128];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: operates on byte lanes of the expected memory image.
  function automatic void ref_op(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd,
                                 output bit flt, output int lat, output int nwr);
    int nb, off;
    logic [31:0] w, m, v;
    nb  = f3[1] ? 4 : (f3[0] ? 2 : 1);
    off = (nb == 4) ? 0 : ((nb == 2) ? 2 * int'(a[1]) : int'(a[1:0]));
    flt = 1'b0;
`ifdef MISALIGN_TRAP_EN
    flt = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
`endif
    m   = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    w   = exp_mem[a[8:2]];
    rd  = '0;
    nwr = 0;
    lat = (wr && nb < 4 && !flt) ? 3 : 2;
    if (!flt) begin
      if (!wr) begin
        v = (w >> (8 * off)) & m;
        if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~m;
        rd = v;
      end else begin
        exp_mem[a[8:2]] = (w & ~(m << (8 * off))) | ((wd & m) << (8 * off));
        nwr = 1;
      end
    end
  endfunction

  task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output bit flt,
                        output int lat, output int nwr);
    int w0;
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    w0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    chk("ready_busy", {31'b0, req_ready}, 32'd0);
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("resp_seen", {31'b0, resp_valid}, 32'd1);
    rd  = resp_rdata;
    flt = resp_fault;
    @(posedge clk); #1;
    chk("resp_pulse", {31'b0, resp_valid}, 32'd0);
    chk("ready_after", {31'b0, req_ready}, 32'd1);
    nwr = wr_cnt - w0;
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd;
    int          lat, nwr;
  } vec_t;

  vec_t tv[12];

  initial begin
    logic [31:0] rd, erd, wd, a;
    bit          flt, eflt, wr;
    int          lat, elat, nwr, enwr;
    logic [2:0]  f3;

    tv[0]  = '{1'b1, 3'b010, 32'h100, 32'h8899AABB, 32'h0,        2, 1};
    tv[1]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'hFFFFFFAA, 2, 0};
    tv[2]  = '{1'b0, 3'b100, 32'h101, 32'h0,        32'h000000AA, 2, 0};
    tv[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFF8899, 2, 0};
    tv[4]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h00008899, 2, 0};
    tv[5]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h8899AABB, 2, 0};
    tv[6]  = '{1'b1, 3'b000, 32'h102, 32'hFFFFFF55, 32'h0,        3, 1};
    tv[7]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h8855AABB, 2, 0};
    tv[8]  = '{1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        2, 1};
    tv[9]  = '{1'b0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 2, 0};
    tv[10] = '{1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFF88, 2, 0};
    tv[11] = '{1'b0, 3'b011, 32'h104, 32'h0,        32'hDEADBEEF, 2, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_fault", {31'b0, resp_fault}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_dwrite", mem_data_write, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    rst_n = 1'b1;

    // Preload every word through the DUT so both images start identical.
    for (int i = 0; i < 128; i++) begin
      wd = $urandom;
      ref_op(1'b1, 3'b010, 32'(i * 4), wd, erd, eflt, elat, enwr);
      do_req(1'b1, 3'b010, 32'(i * 4), wd, rd, flt, lat, nwr);
    end

    for (int i = 0; i < 12; i++) begin
      ref_op(tv[i].wr, tv[i].f3, tv[i].a, tv[i].wd, erd, eflt, elat, enwr);
      do_req(tv[i].wr, tv[i].f3, tv[i].a, tv[i].wd, rd, flt, lat, nwr);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
      chk($sformatf("vec%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("vec%0d_writes", i), nwr, tv[i].nwr);
      chk($sformatf("vec%0d_fault", i), {31'b0, flt}, 32'd0);
    end

    // Misaligned word store: faults with trapping, otherwise writes word 0x100.
    ref_op(1'b1, 3'b010, 32'h102, 32'h12345678, erd, eflt, elat, enwr);
    do_req(1'b1, 3'b010, 32'h102, 32'h12345678, rd, flt, lat, nwr);
    chk("mis_fault", {31'b0, flt}, {31'b0, eflt});
    chk("mis_rdata", rd, erd);
    chk("mis_writes", nwr, enwr);
    chk("mis_lat", lat, elat);
    ref_op(1'b0, 3'b010, 32'h100, 32'h0, erd, eflt, elat, enwr);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, rd, flt, lat, nwr);
    chk("mis_readback", rd, erd);

    // Reset asserted while an SH sits in MERGE: the write must be suppressed.
    req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h100; req_wdata = 32'h0000CAFE;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("merge_we", {31'b0, mem_we}, 32'd1);
    nwr = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk("merge_we_gated", {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("merge_rst_writes", wr_cnt - nwr, 32'd0);
    chk("merge_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("merge_rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("merge_rst_addr", mem_address, 32'd0);
    chk("merge_rst_mem", mem[64], exp_mem[64]);

    // Random traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom);
      f3 = 3'($urandom);
      a  = {23'b0, 9'($urandom)};
      wd = $urandom;
      ref_op(wr, f3, a, wd, erd, eflt, elat, enwr);
      do_req(wr, f3, a, wd, rd, flt, lat, nwr);
      chk($sformatf("rnd%0d_rdata", i), rd, erd);
      chk($sformatf("rnd%0d_fault", i), {31'b0, flt}, {31'b0, eflt});
      chk($sformatf("rnd%0d_lat", i), lat, elat);
      chk($sformatf("rnd%0d_writes", i), nwr, enwr);
    end

    for (int i = 0; i < 128; i++) chk($sformatf("mem%0d", i), mem[i], exp_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the core's execute stage and the word-wide `Memory` block. It turns RISC-V byte, halfword and word load/store requests into accesses on `Memory`'s word port, and sign- or zero-extends load data. Because `Memory` only writes full words, sub-word stores are done as a read-modify-write. It drives `Memory`'s `address`, `data_write` and `write_enable`, and consumes its combinational `data_read`.

## Interface
- `N`, default 32: data and address width. Only 32 is supported; byte-lane logic is fixed to 4 lanes.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `req_addr`  in  N  byte address.
- `req_wdata`  in  N  store data; only the low bytes of the access size are used.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  N  extended load data; 0 for stores.
- `resp_fault`  out  1  misaligned-access fault. Constant 0 when `MISALIGN_TRAP_EN` is not defined.
- `mem_address`  out  N  word address `{addr[N-1:2],2'b00}`.
- `mem_data_write`  out  N  word to write.
- `mem_write_enable`  out  1  write strobe into `Memory`.
- `mem_data_read`  in  N  combinational read data from `Memory`.

## Operation
- **Accept.** A request is accepted on a rising edge where `req_valid && req_ready`. All `req_*` fields are latched at that edge and ignored after it.
- **States.** IDLE, ACCESS, MERGE, RESP.
- **IDLE**
  - goes to ACCESS on accept.
- **ACCESS** (`mem_address` comes from the latched address)
  - Load: capture `mem_data_read`, extract the lane, extend. Go to RESP.
  - Word store: `mem_write_enable=1`, `mem_data_write` = latched wdata. Go to RESP.
  - Byte or halfword store: capture `mem_data_read` into the merge register. Go to MERGE.
- **MERGE**
  - `mem_write_enable=1`.
  - `mem_data_write` = captured word with the target lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`.
  - Go to RESP.
- **RESP**
  - `resp_valid=1`; `resp_rdata` and `resp_fault` are valid.
  - Go to IDLE.
- **Lane select.**
  - Byte: `addr[1:0]` selects `data[8*k+7:8*k]`.
  - Halfword: `addr[1]` selects the low or high 16 bits.
- **Extension.**
  - funct3 000/001 sign-extend from bit 7/15.
  - funct3 100/101 zero-extend.
- **Undefined funct3** (011, 110, 111): treated as word. Stores use `funct3[1:0]`.
- **Outside ACCESS and MERGE:** `mem_write_enable=0`, `mem_data_write=0`, and `mem_address` holds the last latched word address.
- **Reset:** `rst_n=0` sampled at any edge forces IDLE and clears all registers.
  - `mem_write_enable` is gated combinationally by `rst_n`, so no write happens on the reset edge, even mid-MERGE.
  - After reset: `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_fault=0`, `mem_address=0`, `mem_data_write=0`, `mem_write_enable=0`.
- **`resp_rdata` and `resp_fault`** hold their value outside RESP. They clear on the next accept.

## Timing
- Accept edge = E0. `req_ready` falls in the cycle after E0 and rises again in the cycle after RESP.
- Load and word store: `resp_valid` is high in the cycle after E1. Latency is 2 cycles.
- Word store: the `Memory` write happens at E1.
- Byte or halfword store: read in the cycle E0–E1, write at E2, `resp_valid` after E2. Latency is 3 cycles.
- Throughput: at most one request per 3 (or 4) cycles. There is no back-to-back accept during RESP.
- No backpressure on the response: `resp_valid` is a pulse and the consumer must take it.

## Configuration
- **`MISALIGN_TRAP_EN` defined:**
  - Misaligned access = halfword with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - It still runs through ACCESS → RESP with 2-cycle latency.
  - `mem_write_enable` stays 0; MERGE is skipped.
  - `resp_rdata=0`, `resp_fault=1`.
- **Not defined:**
  - Misalignment is ignored: halfword uses `addr[1]` only, word ignores `addr[1:0]`.
  - `resp_fault` is tied to 0.

## Test plan
- Preload word 0x100 = 0x8899AABB. LB at 0x101 → `resp_rdata`=0xFFFFFFAA, 2 cycles after accept. LBU at 0x101 → 0x000000AA.
- Same word; LH at 0x102 → 0xFFFF8899. LHU → 0x00008899. LW at 0x100 → 0x8899AABB.
- SB of 0x55 at 0x102 → word 0x100 becomes 0x8855AABB. `mem_write_enable` is high only in MERGE; `resp_valid` comes 3 cycles after accept.
- SW of 0xDEADBEEF at 0x104 → exactly one write at E1; readback 0xDEADBEEF. `req_ready` is low for the 2 cycles after accept.
- Assert `rst_n=0` in the cycle the SH is in MERGE → no write occurs, memory is unchanged, `req_ready=1` after release.
- With `MISALIGN_TRAP_EN`: SW at 0x102 → `resp_fault=1`, `resp_rdata`=0, no write. Without it: same request writes word 0x100.
